// File: rtl/fpu_float_pipe_ctrl_pkg.sv
// Shared types for the FP float control/retiming pipeline.
package fpu_float_pipe_ctrl_pkg;

  localparam int unsigned FP_DATA_W   = 33;
  localparam int unsigned FP_RD_W     = 5;
  localparam int unsigned FP_FFLAGS_W = 5;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } fflags_s;

  // Default-width stage record; the top re-declares it with its own widths.
  typedef struct packed {
    logic                 v;
    logic                 long_op;
    logic [FP_RD_W-1:0]   rd;
    logic [FP_DATA_W-1:0] result;
    fflags_s              fflags;
  } fpu_pipe_stage_s;

endpackage

// File: rtl/fpu_float_pipe_ctrl_if.sv
// Issue, long-unit, writeback and hazard-probe signals of the FP control pipeline.
interface fpu_float_pipe_ctrl_if #(
  parameter int els_p            = 2,
  parameter int data_width_p     = 33,
  parameter int reg_addr_width_p = 5,
  parameter int fflags_width_p   = 5
);
  localparam int InflightW = $clog2(els_p + 1);

  logic [els_p-1:0]                  stall_i;
  logic                              v_i;
  logic                              long_i;
  logic [reg_addr_width_p-1:0]       rd_i;
  logic [data_width_p-1:0]           short_result_i;
  logic [fflags_width_p-1:0]         short_fflags_i;
  logic                              long_v_i;
  logic [data_width_p-1:0]           long_result_i;
  logic [fflags_width_p-1:0]         long_fflags_i;
  logic                              v_o;
  logic [data_width_p-1:0]           result_o;
  logic [fflags_width_p-1:0]         fflags_o;
  logic [reg_addr_width_p-1:0]       rd_o;
  logic [els_p-1:0]                  stage_v_o;
  logic [els_p*reg_addr_width_p-1:0] stage_rd_o;
  logic [reg_addr_width_p-1:0]       check_rd_i;
  logic                              check_hit_o;
  logic [InflightW-1:0]              inflight_o;
  logic                              err_o;

  modport master (
    output stall_i, v_i, long_i, rd_i, short_result_i, short_fflags_i,
           long_v_i, long_result_i, long_fflags_i, check_rd_i,
    input  v_o, result_o, fflags_o, rd_o, stage_v_o, stage_rd_o,
           check_hit_o, inflight_o, err_o
  );

  modport slave (
    input  stall_i, v_i, long_i, rd_i, short_result_i, short_fflags_i,
           long_v_i, long_result_i, long_fflags_i, check_rd_i,
    output v_o, result_o, fflags_o, rd_o, stage_v_o, stage_rd_o,
           check_hit_o, inflight_o, err_o
  );
endinterface

// File: rtl/fpu_float_pipe_ctrl_stage.sv
// One pipeline stage register: hold on own stall, bubble when upstream stalls, else load.
module fpu_float_pipe_ctrl_stage
  import fpu_float_pipe_ctrl_pkg::*;
#(
  parameter type stage_t = fpu_pipe_stage_s
) (
  input  logic   clk_i,
  input  logic   reset_n_i,
  input  logic   hold_i,
  input  logic   bubble_i,
  input  stage_t d_i,
  output stage_t q_o
);

  stage_t stage_q, stage_d;

  // Payload only moves with a valid op so a bubble keeps the old rd/result.
  always_comb begin
    stage_d = stage_q;
    if (!hold_i) begin
      if (bubble_i) begin
        stage_d.v = 1'b0;
      end else if (d_i.v) begin
        stage_d = d_i;
      end else begin
        stage_d.v = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) stage_q <= '0;
    else            stage_q <= stage_d;
  end

  assign q_o = stage_q;

endmodule

// File: rtl/fpu_float_pipe_ctrl.sv
// FP float control pipeline: carries rd/op class/short results alongside the long unit
// and selects the final writeback; exposes per-stage state for bypass/stall logic.
module fpu_float_pipe_ctrl
  import fpu_float_pipe_ctrl_pkg::*;
#(
  parameter int els_p            = 2,
  parameter int data_width_p     = FP_DATA_W,
  parameter int reg_addr_width_p = FP_RD_W,
  parameter int fflags_width_p   = FP_FFLAGS_W
) (
  input logic                  clk_i,
  input logic                  reset_n_i,
  fpu_float_pipe_ctrl_if.slave bus
);

  localparam int InflightW = $clog2(els_p + 1);

  typedef struct packed {
    logic                        v;
    logic                        long_op;
    logic [reg_addr_width_p-1:0] rd;
    logic [data_width_p-1:0]     result;
    logic [fflags_width_p-1:0]   fflags;
  } stage_t;

  stage_t                            stage_in [els_p];
  stage_t                            stage_q  [els_p];
  stage_t                            last;
  logic   [els_p-1:0]                bubble;
  logic   [els_p-1:0]                stall_order_bad;
  logic   [els_p-1:0]                stage_v;
  logic   [els_p*reg_addr_width_p-1:0] stage_rd;
  logic   [InflightW-1:0]            inflight;
  logic                              hit;
  logic                              stall_order_err;
  logic                              long_v_err;
  logic                              err_q, err_d;

  // Stage k bubbles when stage k-1 is stalled; stage 0 never bubbles.
  assign bubble          = {bus.stall_i[els_p-2:0], 1'b0};
  assign stall_order_bad = bus.stall_i & ~{bus.stall_i[els_p-2:0], 1'b1};
  assign stall_order_err = |stall_order_bad;

  genvar gi;
  generate
    for (gi = 0; gi < els_p; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign stage_in[gi] = '{v:       bus.v_i,
                                long_op: bus.long_i,
                                rd:      bus.rd_i,
                                result:  bus.short_result_i,
                                fflags:  bus.short_fflags_i};
      end else begin : g_body
        assign stage_in[gi] = stage_q[gi-1];
      end

      fpu_float_pipe_ctrl_stage #(.stage_t(stage_t)) u_stage (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .hold_i   (bus.stall_i[gi]),
        .bubble_i (bubble[gi]),
        .d_i      (stage_in[gi]),
        .q_o      (stage_q[gi])
      );

      assign stage_v[gi]                                        = stage_q[gi].v;
      assign stage_rd[gi*reg_addr_width_p +: reg_addr_width_p] = stage_q[gi].rd;
    end
  endgenerate

  assign last = stage_q[els_p-1];

  // The final stage is already on the bypass path, so it is excluded from the hazard probe.
  always_comb begin
    inflight = '0;
    hit      = 1'b0;
    for (int k = 0; k < els_p; k++) begin
      inflight = inflight + InflightW'(stage_q[k].v);
    end
    for (int k = 0; k < els_p - 1; k++) begin
      if (stage_q[k].v && (stage_q[k].rd == bus.check_rd_i)) hit = 1'b1;
    end
  end

  assign long_v_err = bus.long_v_i != (last.v & last.long_op);
  assign err_d      = err_q | stall_order_err | long_v_err;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) err_q <= 1'b0;
    else            err_q <= err_d;
  end

  assign bus.v_o         = last.v;
  assign bus.rd_o        = last.rd;
  assign bus.result_o    = last.long_op ? bus.long_result_i : last.result;
  assign bus.fflags_o    = last.long_op ? bus.long_fflags_i : last.fflags;
  assign bus.stage_v_o   = stage_v;
  assign bus.stage_rd_o  = stage_rd;
  assign bus.check_hit_o = hit;
  assign bus.inflight_o  = inflight;
  assign bus.err_o       = err_q;

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (reset_n_i) begin
      assert (!stall_order_err) else $warning("stall_i[k] asserted without stall_i[k-1]");
      assert (!long_v_err) else $warning("long_v_i disagrees with final stage long op");
    end
  end
`endif

endmodule
